// File: rtl/rgmii_idelay_scan.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_idelay_scan
// Brief    : Sweeps every IDELAY tap of each RGMII lane, scores each tap from
//            the receive checker's good/bad sample pulses and loads the centre
//            of the widest clean tap window (or a fallback tap).
// Revision : 1.0 - initial release
// ============================================================================
module rgmii_idelay_scan #(
    parameter int N_LANES     = 5,
    parameter int TAP_W       = 5,
    parameter int SETTLE      = 16,
    parameter int DWELL       = 4096,
    parameter int MIN_OK      = 64,
    parameter int DEFAULT_TAP = 12,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         manual_stb,
    input  logic [$clog2(N_LANES)-1:0]   manual_lane,
    input  logic [TAP_W-1:0]             manual_tap,
    input  logic                         sample_ok,
    input  logic                         sample_err,
    output logic [N_LANES-1:0]           idelay_ce,
    output logic [TAP_W-1:0]             idelay_value,
    output logic                         busy,
    output logic                         done,
    output logic [N_LANES-1:0]           lane_fail,
    output logic [N_LANES*TAP_W-1:0]     result_tap
);

    localparam int                c_LANE_W    = $clog2(N_LANES);
    localparam int                c_PH_MAX    = (SETTLE > DWELL) ? SETTLE : DWELL;
    localparam int                c_PH_W      = $clog2(c_PH_MAX + 1);
    localparam logic [TAP_W-1:0]  c_TAP_MAX   = {TAP_W{1'b1}};
    localparam logic [TAP_W-1:0]  c_DEF_TAP   = TAP_W'(DEFAULT_TAP);
    localparam logic [CNT_W-1:0]  c_MIN_OK    = CNT_W'(MIN_OK);
    localparam logic [c_LANE_W-1:0] c_LANE_LAST = c_LANE_W'(N_LANES - 1);
    localparam logic [c_PH_W-1:0] c_SETTLE_LAST = c_PH_W'(SETTLE - 1);
    localparam logic [c_PH_W-1:0] c_DWELL_LAST  = c_PH_W'(DWELL - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_SETTLE = 3'd2;
    localparam logic [2:0] c_ST_DWELL  = 3'd3;
    localparam logic [2:0] c_ST_EVAL   = 3'd4;
    localparam logic [2:0] c_ST_CENTER = 3'd5;
    localparam logic [2:0] c_ST_DONE   = 3'd6;

    logic [2:0]               r_state;
    logic [c_LANE_W-1:0]      r_lane;
    logic [TAP_W-1:0]         r_tap;
    logic [c_PH_W-1:0]        r_phase;
    logic [CNT_W-1:0]         r_ok_cnt;
    logic [CNT_W-1:0]         r_err_cnt;
    logic [TAP_W-1:0]         r_run_start;
    logic [TAP_W:0]           r_run_len;
    logic [TAP_W-1:0]         r_best_start;
    logic [TAP_W:0]           r_best_len;
    logic [N_LANES-1:0]       r_idelay_ce;
    logic [TAP_W-1:0]         r_idelay_value;
    logic                     r_busy;
    logic                     r_done;
    logic [N_LANES-1:0]       r_lane_fail;
    logic [N_LANES*TAP_W-1:0] r_result_tap;

    logic                     w_good;
    logic [TAP_W-1:0]         w_run_start;
    logic [TAP_W:0]           w_run_len;
    logic [TAP_W-1:0]         w_best_start;
    logic [TAP_W:0]           w_best_len;
    logic [TAP_W-1:0]         w_len_m1;
    logic [TAP_W-1:0]         w_final_tap;
    logic [N_LANES-1:0]       w_lane_oh;
    logic [N_LANES-1:0]       w_next_lane_oh;
    logic [N_LANES-1:0]       w_manual_oh;
    logic                     w_manual_ok;

    // Run tracker as it will stand after the tap being evaluated; the best run
    // is only replaced by a strictly longer one, so the earliest run wins ties.
    always_comb begin
        w_good       = (r_err_cnt == '0) && (r_ok_cnt >= c_MIN_OK);
        w_run_start  = r_run_start;
        w_run_len    = '0;
        if (w_good) begin
            w_run_len = r_run_len + 1'b1;
            if (r_run_len == '0) begin
                w_run_start = r_tap;
            end
        end
        w_best_start = r_best_start;
        w_best_len   = r_best_len;
        if (w_run_len > r_best_len) begin
            w_best_start = w_run_start;
            w_best_len   = w_run_len;
        end
        // A full-width window has length 2^TAP_W, whose low bits minus one
        // still give the correct (len-1) in TAP_W bits.
        w_len_m1     = w_best_len[TAP_W-1:0] - 1'b1;
        w_final_tap  = (w_best_len == '0) ? c_DEF_TAP : (w_best_start + (w_len_m1 >> 1));
    end

    assign w_lane_oh      = N_LANES'(1) << r_lane;
    assign w_next_lane_oh = N_LANES'(1) << (r_lane + 1'b1);
    assign w_manual_oh    = N_LANES'(1) << manual_lane;
    assign w_manual_ok    = (32'(manual_lane) < N_LANES);

    always_ff @(posedge clk) begin
        r_idelay_ce <= '0;
        r_done      <= 1'b0;
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_lane         <= '0;
            r_tap          <= '0;
            r_phase        <= '0;
            r_ok_cnt       <= '0;
            r_err_cnt      <= '0;
            r_run_start    <= '0;
            r_run_len      <= '0;
            r_best_start   <= '0;
            r_best_len     <= '0;
            r_idelay_value <= '0;
            r_busy         <= 1'b0;
            r_lane_fail    <= '0;
            r_result_tap   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state        <= c_ST_LOAD;
                        r_lane         <= '0;
                        r_tap          <= '0;
                        r_busy         <= 1'b1;
                        r_idelay_ce    <= N_LANES'(1);
                        r_idelay_value <= '0;
                        r_run_start    <= '0;
                        r_run_len      <= '0;
                        r_best_start   <= '0;
                        r_best_len     <= '0;
                    end else if (manual_stb && w_manual_ok) begin
                        r_idelay_ce    <= w_manual_oh;
                        r_idelay_value <= manual_tap;
                    end
                end
                c_ST_LOAD: begin
                    r_ok_cnt  <= '0;
                    r_err_cnt <= '0;
                    r_phase   <= '0;
                    r_state   <= c_ST_SETTLE;
                end
                c_ST_SETTLE: begin
                    if (r_phase == c_SETTLE_LAST) begin
                        r_phase <= '0;
                        r_state <= c_ST_DWELL;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                c_ST_DWELL: begin
                    if (sample_ok && (r_ok_cnt != '1)) begin
                        r_ok_cnt <= r_ok_cnt + 1'b1;
                    end
                    if (sample_err && (r_err_cnt != '1)) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                    if (r_phase == c_DWELL_LAST) begin
                        r_phase <= '0;
                        r_state <= c_ST_EVAL;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                c_ST_EVAL: begin
                    r_run_start  <= w_run_start;
                    r_run_len    <= w_run_len;
                    r_best_start <= w_best_start;
                    r_best_len   <= w_best_len;
                    r_idelay_ce  <= w_lane_oh;
                    if (r_tap != c_TAP_MAX) begin
                        r_tap          <= r_tap + 1'b1;
                        r_idelay_value <= r_tap + 1'b1;
                        r_state        <= c_ST_LOAD;
                    end else begin
                        // The lane's final tap and status become visible in CENTER.
                        r_idelay_value                       <= w_final_tap;
                        r_result_tap[r_lane*TAP_W +: TAP_W]  <= w_final_tap;
                        r_lane_fail[r_lane]                  <= (w_best_len == '0);
                        r_state                              <= c_ST_CENTER;
                    end
                end
                c_ST_CENTER: begin
                    if (r_lane != c_LANE_LAST) begin
                        r_lane         <= r_lane + 1'b1;
                        r_tap          <= '0;
                        r_idelay_ce    <= w_next_lane_oh;
                        r_idelay_value <= '0;
                        r_run_start    <= '0;
                        r_run_len      <= '0;
                        r_best_start   <= '0;
                        r_best_len     <= '0;
                        r_state        <= c_ST_LOAD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign idelay_ce    = r_idelay_ce;
    assign idelay_value = r_idelay_value;
    assign busy         = r_busy;
    assign done         = r_done;
    assign lane_fail    = r_lane_fail;
    assign result_tap   = r_result_tap;

endmodule
`default_nettype wire

// File: tb/tb_rgmii_idelay_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgmii_idelay_scan
// Brief    : Self-checking bench for rgmii_idelay_scan with a per-tap channel
//            model and a schedule/window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgmii_idelay_scan;

    localparam int NL       = 2;
    localparam int TW       = 3;
    localparam int ST       = 2;
    localparam int DW       = 8;
    localparam int MOK      = 4;
    localparam int DT       = 4;
    localparam int CW       = 16;
    localparam int LW       = $clog2(NL);
    localparam int NT       = 1 << TW;
    localparam int PER_TAP  = ST + DW + 2;
    localparam int SWEEP    = NT * PER_TAP;
    localparam int PER_LANE = SWEEP + 1;
    localparam int TOTAL    = NL * PER_LANE + 1;

    logic            clk         = 1'b0;
    logic            reset       = 1'b1;
    logic            start       = 1'b0;
    logic            manual_stb  = 1'b0;
    logic [LW-1:0]   manual_lane = '0;
    logic [TW-1:0]   manual_tap  = '0;
    logic            sample_ok   = 1'b0;
    logic            sample_err  = 1'b0;
    logic [NL-1:0]   idelay_ce;
    logic [TW-1:0]   idelay_value;
    logic            busy;
    logic            done;
    logic [NL-1:0]   lane_fail;
    logic [NL*TW-1:0] result_tap;

    rgmii_idelay_scan #(
        .N_LANES(NL), .TAP_W(TW), .SETTLE(ST), .DWELL(DW),
        .MIN_OK(MOK), .DEFAULT_TAP(DT), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .manual_stb(manual_stb),
        .manual_lane(manual_lane), .manual_tap(manual_tap),
        .sample_ok(sample_ok), .sample_err(sample_err),
        .idelay_ce(idelay_ce), .idelay_value(idelay_value), .busy(busy),
        .done(done), .lane_fail(lane_fail), .result_tap(result_tap)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel quality per (lane, tap): 0 clean, 1 one err with ok, 2 three oks,
    // 3 exactly MIN_OK oks, 4 random, 5 err every cycle.
    int mode [NL][NT];
    int okc  [NL][NT];
    int errc [NL][NT];

    int              m_off = 0;   // 0 = idle, else cycle number within a scan
    logic [NL-1:0]   e_ce   = '0;
    logic [TW-1:0]   e_val  = '0;
    logic            e_busy = 1'b0;
    logic            e_done = 1'b0;
    logic [NL*TW-1:0] e_res = '0;
    logic [NL-1:0]   e_fail = '0;
    logic [NL-1:0]   last_ce  = '0;
    logic [TW-1:0]   last_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void locate(input int off, output int l, output int t, output int ph, output bit ctr);
        int r;
        r   = (off - 1) % PER_LANE;
        l   = (off - 1) / PER_LANE;
        ctr = (r == SWEEP);
        t   = r / PER_TAP;
        ph  = r % PER_TAP;
    endfunction

    // Widest all-good window by exhaustive search; earliest wins on ties.
    function automatic int center_of(input int l, output bit fail);
        int bs, bl;
        bit all_good;
        bs = 0;
        bl = 0;
        for (int s = 0; s < NT; s++) begin
            for (int e = s; e < NT; e++) begin
                all_good = 1'b1;
                for (int k = s; k <= e; k++)
                    if (!(errc[l][k] == 0 && okc[l][k] >= MOK)) all_good = 1'b0;
                if (all_good && (e - s + 1) > bl) begin
                    bl = e - s + 1;
                    bs = s;
                end
            end
        end
        fail = (bl == 0);
        return fail ? DT : bs + (bl - 1) / 2;
    endfunction

    initial begin : model
        int  l, t, ph, c;
        bit  ctr, f;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_off  = 0;
                e_ce   = '0;
                e_val  = '0;
                e_busy = 1'b0;
                e_done = 1'b0;
                e_res  = '0;
                e_fail = '0;
            end else begin
                e_ce   = '0;
                e_done = 1'b0;
                if (m_off == 0) begin
                    if (start) m_off = 1;
                    else if (manual_stb && int'(manual_lane) < NL) begin
                        e_ce[manual_lane] = 1'b1;
                        e_val = manual_tap;
                    end
                end else begin
                    if (m_off < TOTAL) begin
                        locate(m_off, l, t, ph, ctr);
                        if (!ctr && ph > ST && ph <= ST + DW) begin
                            okc[l][t]  += int'(sample_ok);
                            errc[l][t] += int'(sample_err);
                        end
                    end
                    m_off = (m_off == TOTAL) ? 0 : m_off + 1;
                end
                e_busy = (m_off > 0 && m_off < TOTAL);
                e_done = (m_off == TOTAL);
                if (m_off > 0 && m_off < TOTAL) begin
                    locate(m_off, l, t, ph, ctr);
                    if (ctr) begin
                        c = center_of(l, f);
                        e_ce[l] = 1'b1;
                        e_val   = TW'(c);
                        e_res[l*TW +: TW] = TW'(c);
                        e_fail[l] = f;
                    end else if (ph == 0) begin
                        e_ce[l]    = 1'b1;
                        e_val      = TW'(t);
                        okc[l][t]  = 0;
                        errc[l][t] = 0;
                    end
                end
            end
        end
    end

    // Receive-checker stand-in: samples depend on the tap under test; noise elsewhere.
    initial begin : drive
        int l, t, ph, i;
        bit ctr;
        forever begin
            @(negedge clk);
            sample_ok  = 1'($urandom % 2);
            sample_err = 1'($urandom % 2);
            if (m_off > 0 && m_off < TOTAL) begin
                locate(m_off, l, t, ph, ctr);
                if (!ctr && ph > ST && ph <= ST + DW) begin
                    i = ph - ST - 1;
                    case (mode[l][t])
                        0: begin sample_ok = 1'b1;      sample_err = 1'b0; end
                        1: begin sample_ok = 1'b1;      sample_err = (i == DW / 2); end
                        2: begin sample_ok = (i < 3);   sample_err = 1'b0; end
                        3: begin sample_ok = (i < MOK); sample_err = 1'b0; end
                        4: begin sample_ok = 1'($urandom % 2); sample_err = ($urandom % 8 == 0); end
                        default: begin sample_ok = 1'b1; sample_err = 1'b1; end
                    endcase
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("idelay_ce", idelay_ce, e_ce);
                if (e_ce != '0) check("idelay_value", idelay_value, e_val);
                check("busy", busy, e_busy);
                check("done", done, e_done);
                check("result_tap", result_tap, e_res);
                check("lane_fail", lane_fail, e_fail);
                if (idelay_ce != '0) begin
                    last_ce  = idelay_ce;
                    last_val = idelay_value;
                end
            end
        end
    end

    task automatic set_modes(input int l, input int m0, input int m1, input int m2, input int m3,
                             input int m4, input int m5, input int m6, input int m7);
        mode[l][0] = m0; mode[l][1] = m1; mode[l][2] = m2; mode[l][3] = m3;
        mode[l][4] = m4; mode[l][5] = m5; mode[l][6] = m6; mode[l][7] = m7;
    endtask

    // inject: 0 none, 1 start+manual while busy, 2 reset in lane 0 tap 3 dwell,
    // 3 start and manual in the same idle cycle.
    task automatic run_scan(input string tag, input int inject, output int dur);
        int c0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        if (inject == 3) begin
            manual_stb = 1'b1; manual_lane = 1'b0; manual_tap = 3'd7;
        end
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        manual_stb = 1'b0;
        if (inject == 3) begin
            check({tag, "_prio_ce"}, idelay_ce, 2'b01);
            check({tag, "_prio_val"}, idelay_value, 3'd0);
        end
        dur = -1;
        for (int n = 0; n < TOTAL + 50; n++) begin
            if (done) begin
                dur = cyc - c0;
                break;
            end
            if (inject == 1 && cyc - c0 == 50) begin
                start = 1'b1; manual_stb = 1'b1; manual_lane = 1'b1; manual_tap = 3'd2;
                @(negedge clk);
                start = 1'b0; manual_stb = 1'b0;
                check({tag, "_busy_manual_ce"}, idelay_ce, 2'b00);
            end else if (inject == 2 && cyc - c0 == 40) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check({tag, "_rst_busy"}, busy, 1'b0);
                check({tag, "_rst_ce"}, idelay_ce, 2'b00);
                check({tag, "_rst_result"}, result_tap, 6'd0);
                check({tag, "_rst_fail"}, lane_fail, 2'b00);
                return;
            end else begin
                @(negedge clk);
            end
        end
        if (dur < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done got none, required within %0d cycles", tag, TOTAL + 50);
        end
    endtask

    initial begin : main
        int d;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ce", idelay_ce, 2'b00);
        check("reset_value", idelay_value, 3'd0);
        check("reset_result", result_tap, 6'd0);
        check("reset_fail", lane_fail, 2'b00);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Window 2..5 on lane 0, lane 1 dead.
        set_modes(0, 1, 1, 0, 0, 0, 0, 1, 1);
        set_modes(1, 5, 5, 5, 5, 5, 5, 5, 5);
        run_scan("s1", 0, d);
        check("s1_latency", d, TOTAL);
        check("s1_lat_literal", d, 195);
        check("s1_res0", result_tap[2:0], 3'd3);
        check("s1_res1", result_tap[5:3], 3'd4);
        check("s1_fail", lane_fail, 2'b10);
        check("s1_last_ce", last_ce, 2'b10);
        check("s1_last_val", last_val, 3'd4);
        check("s1_model_res", e_res, 6'h23);

        // Equal-length windows {0,1} and {5,6}; tap 5 sits exactly at MIN_OK.
        set_modes(0, 0, 0, 2, 1, 5, 3, 0, 5);
        set_modes(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_scan("s2", 0, d);
        check("s2_result", result_tap, 6'h18);
        check("s2_fail", lane_fail, 2'b00);
        check("s2_model_res", e_res, 6'h18);

        // Window closed at the top tap; single-tap window on lane 1.
        set_modes(0, 1, 2, 5, 1, 2, 5, 0, 0);
        set_modes(1, 2, 2, 2, 3, 2, 2, 2, 2);
        run_scan("s3", 0, d);
        check("s3_result", result_tap, 6'h1e);
        check("s3_fail", lane_fail, 2'b00);
        check("s3_model_res", e_res, 6'h1e);

        // Manual load in idle.
        @(negedge clk);
        manual_stb = 1'b1; manual_lane = 1'b1; manual_tap = 3'd5;
        @(negedge clk);
        manual_stb = 1'b0;
        check("manual_ce", idelay_ce, 2'b10);
        check("manual_val", idelay_value, 3'd5);
        @(negedge clk);
        check("manual_once", idelay_ce, 2'b00);

        for (int s = 0; s < 4; s++) begin
            for (int l = 0; l < NL; l++)
                for (int t = 0; t < NT; t++)
                    mode[l][t] = ($urandom % 2) ? 0 : int'($urandom_range(1, 5));
            run_scan("rand", (s == 1) ? 1 : 0, d);
            check("rand_latency", d, TOTAL);
        end

        set_modes(0, 1, 1, 0, 0, 0, 0, 1, 1);
        set_modes(1, 5, 5, 5, 5, 5, 5, 5, 5);
        run_scan("prio", 3, d);
        check("prio_result", result_tap, 6'h23);

        run_scan("abort", 2, d);
        repeat (4) @(negedge clk);

        set_modes(0, 0, 0, 2, 1, 5, 3, 0, 5);
        set_modes(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_scan("rescan", 0, d);
        check("rescan_latency", d, TOTAL);
        check("rescan_result", result_tap, 6'h18);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/rgmii_idelay_scan.md
RGMII_IDELAY_SCAN -- requirements
Module: rgmii_idelay_scan

Interface
REQ-001 SHALL have parameter N_LANES, default 5, giving the IDELAY lane count (4 RXD plus RX_CTL).
REQ-002 SHALL have parameter TAP_W, default 5, giving the tap value width; the tap range is 0..2^TAP_W-1.
REQ-003 SHALL have parameter SETTLE, default 16, giving the cycles waited after a tap load before counting.
REQ-004 SHALL have parameter DWELL, default 4096, giving the counting-window length in cycles.
REQ-005 SHALL have parameter MIN_OK, default 64, giving the minimum sample_ok count for a tap to be good.
REQ-006 SHALL have parameter DEFAULT_TAP, default 12, giving the tap loaded when a lane has no good tap.
REQ-007 SHALL have parameter CNT_W, default 16, giving the width of the saturating ok/err counters.
REQ-008 SHALL have port clk, input, 1 bit: the single clock, which is the IDELAY control clock.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port start, input, 1 bit: single-cycle request to begin an auto scan.
REQ-011 SHALL have port manual_stb, input, 1 bit: single-cycle request for a manual tap load.
REQ-012 SHALL have port manual_lane, input, $clog2(N_LANES) bits: lane targeted by a manual load.
REQ-013 SHALL have port manual_tap, input, TAP_W bits: tap value for a manual load.
REQ-014 SHALL have port sample_ok, input, 1 bit: pulse from the receive checker marking one good sample.
REQ-015 SHALL have port sample_err, input, 1 bit: pulse from the receive checker marking one bad sample.
REQ-016 SHALL have port idelay_ce, output, N_LANES bits: one-hot, single-cycle per-lane load strobe.
REQ-017 SHALL have port idelay_value, output, TAP_W bits: tap value, valid in the same cycle as idelay_ce.
REQ-018 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-019 SHALL have port done, output, 1 bit: single-cycle pulse at scan completion.
REQ-020 SHALL have port lane_fail, output, N_LANES bits: per-lane flag, set when the lane had no good tap.
REQ-021 SHALL have port result_tap, output, N_LANES*TAP_W bits: per-lane chosen tap; lane i occupies bits [i*TAP_W +: TAP_W].

Function
REQ-022 SHALL implement FSM states IDLE, LOAD, SETTLE, DWELL, EVAL, CENTER, DONE.
REQ-023 SHALL, in IDLE, move to LOAD on start with lane=0 and tap=0, and set busy starting the next cycle.
REQ-024 SHALL, in LOAD (1 cycle), assert idelay_ce[lane] with idelay_value=tap, clear both counters, then go to SETTLE.
REQ-025 SHALL stay in SETTLE exactly SETTLE cycles; samples in SETTLE are ignored.
REQ-026 SHALL stay in DWELL exactly DWELL cycles, counting sample_ok and sample_err into separate CNT_W counters that saturate at all-ones; when both pulses arrive in one cycle, both counters increment.
REQ-027 SHALL, in EVAL (1 cycle), judge the tap good iff err_cnt==0 and ok_cnt>=MIN_OK, and update the run tracker.
REQ-028 SHALL have the run tracker keep the current contiguous good run and the best run (start, length); a strictly longer run replaces the best; on equal length the earlier run is kept.
REQ-029 SHALL close an open run at the top tap (2^TAP_W-1); runs SHALL NOT wrap to tap 0.
REQ-030 SHALL, after EVAL, go to LOAD with tap+1 if tap is below the maximum, otherwise go to CENTER.
REQ-031 SHALL, in CENTER (1 cycle), set result = best_start + ((best_len-1)>>1) if best_len>0, clear lane_fail[lane], and pulse idelay_ce[lane] with idelay_value=result.
REQ-032 SHALL, in CENTER with best_len==0, set result=DEFAULT_TAP, set lane_fail[lane], and pulse idelay_ce[lane] with DEFAULT_TAP.
REQ-033 SHALL, after CENTER, go to LOAD with lane+1 and tap=0 if lane<N_LANES-1, otherwise go to DONE.
REQ-034 SHALL, in DONE (1 cycle), pulse done, drop busy, and return to IDLE.
REQ-035 SHALL take exactly 2^TAP_W*(SETTLE+DWELL+2)+1 cycles per lane.
REQ-036 SHALL ignore start while busy.
REQ-037 SHALL, in IDLE, on manual_stb, pulse idelay_ce[manual_lane] with idelay_value=manual_tap in the next cycle.
REQ-038 SHALL ignore manual_stb while busy and when manual_lane>=N_LANES.
REQ-039 SHALL update result_tap and lane_fail only in CENTER, holding them otherwise.
REQ-040 SHALL give start priority over manual_stb when both arrive in the same IDLE cycle.

Reset
REQ-041 SHALL, on reset, go to IDLE and clear idelay_ce, idelay_value, busy, done, lane_fail, result_tap, the counters, and the run tracker, all to 0.
REQ-042 SHALL, on reset mid-scan, abort with no further idelay_ce pulse; the next start SHALL rescan from lane 0, tap 0.

Verification
REQ-043 SHALL be verified with N_LANES=2, TAP_W=3, SETTLE=2, DWELL=8, MIN_OK=4, DEFAULT_TAP=4, sample_ok held high except where stated, across these directed scenarios:
- Lane 0 errors outside taps 2..5 -> result_tap[2:0]=3, lane_fail[0]=0; done exactly 195 cycles after start is sampled.
- Lane 0 good taps {0,1,5,6} -> result 0 (equal-length tie, earlier run kept).
- Lane 0 good taps 6..7 only -> result 6; run closed at the top tap.
- Lane 1 sample_err every cycle -> lane_fail[1]=1, result_tap[5:3]=4, CENTER pulses idelay_ce=2'b10 with value 4.
- sample_ok and sample_err simultaneous in a tap -> tap bad; sample_ok only at 3 per dwell -> tap bad (below MIN_OK).
- Reset during lane 0 tap 3 DWELL -> next cycle busy=0, idelay_ce=0, result_tap=0; manual_stb lane 1 tap 5 in IDLE -> idelay_ce=2'b10, value 5 next cycle; same request while busy -> no pulse.
